parking_system: RTL and testbench



---
 rtl/parking_system.sv | 125 ++++++++++++
 tb/tb_parking_system.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/parking_system.sv
// Car park gate controller: waits a fixed interval for a two-digit password,
// then grants or refuses entry. LEDs and 7-segment digits are registered one cycle behind the state.
module parking_system (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_entrance,
    input  logic       sensor_exit,
    input  logic [1:0] password_1,
    input  logic [1:0] password_2,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic [6:0] HEX_1,
    output logic [6:0] HEX_2
);
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        STOP          = 3'd4
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_G     = 7'b0000010;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       green_q, green_d;
    logic       red_q, red_d;
    logic [6:0] hex1_q, hex1_d;
    logic [6:0] hex2_q, hex2_d;
    logic       pass_ok;

    assign pass_ok = (password_1 == 2'b01) && (password_2 == 2'b10);

    // The counter is held at zero outside WAIT_PASSWORD, which clears it on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (sensor_entrance) state_d = WAIT_PASSWORD;
            end
            WAIT_PASSWORD: begin
                if (cnt_q <= 3'd3) begin
                    cnt_d = cnt_q + 3'd1;
                end else if (pass_ok) begin
                    state_d = RIGHT_PASS;
                end else begin
                    state_d = WRONG_PASS;
                end
            end
            WRONG_PASS: begin
                if (pass_ok) state_d = RIGHT_PASS;
            end
            RIGHT_PASS: begin
                if (sensor_entrance && sensor_exit) state_d = STOP;
                else if (sensor_exit)               state_d = IDLE;
            end
            STOP: begin
                if (pass_ok) state_d = RIGHT_PASS;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        green_d = 1'b0;
        red_d   = 1'b0;
        hex1_d  = SEG_BLANK;
        hex2_d  = SEG_BLANK;
        unique case (state_q)
            IDLE: ;
            WAIT_PASSWORD: begin
                red_d  = 1'b1;
                hex1_d = SEG_E;
                hex2_d = SEG_N;
            end
            WRONG_PASS: begin
                red_d  = ~red_q;
                hex1_d = SEG_E;
                hex2_d = SEG_E;
            end
            RIGHT_PASS: begin
                green_d = ~green_q;
                hex1_d  = SEG_G;
                hex2_d  = SEG_O;
            end
            STOP: begin
                red_d  = ~red_q;
                hex1_d = SEG_S;
                hex2_d = SEG_P;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            green_q <= 1'b0;
            red_q   <= 1'b0;
            hex1_q  <= SEG_BLANK;
            hex2_q  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            green_q <= green_d;
            red_q   <= red_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
        end
    end

    assign GREEN_LED = green_q;
    assign RED_LED   = red_q;
    assign HEX_1     = hex1_q;
    assign HEX_2     = hex2_q;
endmodule

// File: tb/tb_parking_system.sv
// Directed self-checking bench for parking_system; expectations are hand-derived
// from the state timing (outputs lag state by one clock).
module tb_parking_system;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       GREEN_LED;
    logic       RED_LED;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;

    int unsigned checks = 0;
    int unsigned passed = 0;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] E  = 7'b0000110;
    localparam logic [6:0] N  = 7'b0101011;
    localparam logic [6:0] G  = 7'b0000010;
    localparam logic [6:0] O  = 7'b1000000;
    localparam logic [6:0] S  = 7'b0010010;
    localparam logic [6:0] P  = 7'b0001100;

    parking_system dut (
        .clk(clk),
        .reset_n(reset_n),
        .sensor_entrance(sensor_entrance),
        .sensor_exit(sensor_exit),
        .password_1(password_1),
        .password_2(password_2),
        .GREEN_LED(GREEN_LED),
        .RED_LED(RED_LED),
        .HEX_1(HEX_1),
        .HEX_2(HEX_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic g, input logic r,
                           input logic [6:0] h1, input logic [6:0] h2);
        chk({tag, ".green"}, {6'b0, GREEN_LED}, {6'b0, g});
        chk({tag, ".red"},   {6'b0, RED_LED},   {6'b0, r});
        chk({tag, ".hex1"},  HEX_1, h1);
        chk({tag, ".hex2"},  HEX_2, h2);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        sensor_entrance = 1'b0;
        sensor_exit = 1'b0;
        password_1 = 2'b00;
        password_2 = 2'b00;
        repeat (5) step();
        chk_out("reset", 1'b0, 1'b0, BL, BL);
        reset_n = 1'b1;
        step();
        chk_out("idle1", 1'b0, 1'b0, BL, BL);
        step();
        chk_out("idle2", 1'b0, 1'b0, BL, BL);

        // Arrival with wrong password
        sensor_entrance = 1'b1;
        step();
        chk_out("arrive_wrong", 1'b0, 1'b0, BL, BL);
        sensor_entrance = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("wait_wrong", 1'b0, 1'b1, E, N);
        end
        step();
        chk_out("wrong0", 1'b0, 1'b0, E, E);
        step();
        chk_out("wrong1", 1'b0, 1'b1, E, E);
        step();
        chk_out("wrong2", 1'b0, 1'b0, E, E);

        // Correct password from WRONG_PASS
        password_1 = 2'b01;
        password_2 = 2'b10;
        step();
        chk_out("wrong_to_right", 1'b0, 1'b1, E, E);
        step();
        chk_out("go0", 1'b1, 1'b0, G, O);
        step();
        chk_out("go1", 1'b0, 1'b0, G, O);
        step();
        chk_out("go2", 1'b1, 1'b0, G, O);

        // Car leaves
        sensor_exit = 1'b1;
        step();
        chk_out("exit_edge", 1'b0, 1'b0, G, O);
        sensor_exit = 1'b0;
        step();
        chk_out("exit_idle", 1'b0, 1'b0, BL, BL);

        // Arrival with correct password already present
        sensor_entrance = 1'b1;
        step();
        chk_out("arrive_ok", 1'b0, 1'b0, BL, BL);
        sensor_entrance = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("wait_ok", 1'b0, 1'b1, E, N);
        end
        step();
        chk_out("direct_go0", 1'b1, 1'b0, G, O);
        step();
        chk_out("direct_go1", 1'b0, 1'b0, G, O);

        // Tailgating -> STOP
        sensor_entrance = 1'b1;
        sensor_exit = 1'b1;
        step();
        chk_out("tailgate_edge", 1'b1, 1'b0, G, O);
        sensor_entrance = 1'b0;
        sensor_exit = 1'b0;
        password_1 = 2'b00;
        password_2 = 2'b00;
        step();
        chk_out("stop0", 1'b0, 1'b1, S, P);
        step();
        chk_out("stop1", 1'b0, 1'b0, S, P);
        step();
        chk_out("stop2", 1'b0, 1'b1, S, P);
        password_1 = 2'b01;
        password_2 = 2'b10;
        step();
        chk_out("stop_to_right", 1'b0, 1'b0, S, P);
        step();
        chk_out("stop_go", 1'b1, 1'b0, G, O);

        // Leave, re-arrive, reset mid-WAIT
        sensor_exit = 1'b1;
        step();
        chk_out("exit2_edge", 1'b0, 1'b0, G, O);
        sensor_exit = 1'b0;
        step();
        chk_out("exit2_idle", 1'b0, 1'b0, BL, BL);
        sensor_entrance = 1'b1;
        step();
        sensor_entrance = 1'b0;
        step();
        chk_out("midwait1", 1'b0, 1'b1, E, N);
        step();
        chk_out("midwait2", 1'b0, 1'b1, E, N);
        reset_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b0, BL, BL);
        #2;
        reset_n = 1'b1;
        step();
        chk_out("post_reset_idle", 1'b0, 1'b0, BL, BL);
        sensor_entrance = 1'b1;
        step();
        chk_out("rearrive", 1'b0, 1'b0, BL, BL);
        sensor_entrance = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("rewait", 1'b0, 1'b1, E, N);
        end
        step();
        chk_out("rewait_go", 1'b1, 1'b0, G, O);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
